// File: rtl/encoder_16x4_sync_pkg.sv
// Shared widths and types for the registered 16-to-4 priority encoder.
// Latency: n/a (types only). Backpressure: n/a.
package encoder_16x4_sync_pkg;
  localparam int IN_W  = 16;
  localparam int OUT_W = 4;

  typedef logic [OUT_W-1:0] enc_idx_t;
  typedef logic [IN_W-1:0]  enc_req_t;
endpackage

// File: rtl/encoder_16x4_sync_prio.sv
// 4-input MSB-first priority encoder slice: 2-bit index of highest set bit plus any-set.
// Latency: combinational. Backpressure: none.
module prio_enc_4x2 (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       any
);
  always_comb begin
    idx = 2'd0;
    if (req[3])      idx = 2'd3;
    else if (req[2]) idx = 2'd2;
    else if (req[1]) idx = 2'd1;
    any = |req;
  end
endmodule

// File: rtl/encoder_16x4_sync.sv
// Registered 16-to-4 MSB-first priority encoder with valid; `multi` (>=2 bits set) built under ENCODER_16X4_MULTI_EN.
// Latency: 1 cycle, one encode per cycle. Backpressure: none, `in` sampled every edge.
module encoder_16x4_sync
  import encoder_16x4_sync_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  enc_req_t in,
  output enc_idx_t out,
  output logic     valid
`ifdef ENCODER_16X4_MULTI_EN
  ,
  output logic     multi
`endif
);
  logic [1:0] slice_idx [4];
  logic [3:0] slice_any;
  logic [1:0] grp_idx;
  logic       any_nxt;
  enc_idx_t   out_nxt;

  for (genvar g = 0; g < 4; g++) begin : g_slice
    prio_enc_4x2 u_slice (
      .req (in[g*4 +: 4]),
      .idx (slice_idx[g]),
      .any (slice_any[g])
    );
  end

  // The group encoder picks the highest non-empty nibble; its slice supplies the low bits.
  prio_enc_4x2 u_grp (
    .req (slice_any),
    .idx (grp_idx),
    .any (any_nxt)
  );

  assign out_nxt = {grp_idx, slice_idx[grp_idx]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      out   <= out_nxt;
      valid <= any_nxt;
    end
  end

`ifdef ENCODER_16X4_MULTI_EN
  logic seen;
  logic multi_nxt;

  // Flag goes high on the second set bit encountered.
  always_comb begin
    seen      = 1'b0;
    multi_nxt = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (in[i]) begin
        if (seen) multi_nxt = 1'b1;
        seen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) multi <= 1'b0;
    else     multi <= multi_nxt;
  end
`endif
endmodule

// File: tb/tb_encoder_16x4_sync.sv
// Self-checking bench for encoder_16x4_sync: directed scenarios plus random vectors vs. a bit-scan model.
// Checks `multi` only when ENCODER_16X4_MULTI_EN is defined.
module tb_encoder_16x4_sync;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic [3:0]  out;
  logic        valid;
`ifdef ENCODER_16X4_MULTI_EN
  logic        multi;
`endif

  int          checks = 0;
  int          failures = 0;
  logic        have_exp = 1'b0;
  logic [3:0]  e_out;
  logic        e_valid;
  logic        e_multi;
  string       prev_tag = "";

  always #5 clk = ~clk;

  encoder_16x4_sync dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .out   (out),
    .valid (valid)
`ifdef ENCODER_16X4_MULTI_EN
    ,
    .multi (multi)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: scan every bit, the last set one seen in ascending order is the highest.
  task automatic model(input logic [15:0] v);
    int cnt;
    cnt   = 0;
    e_out = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        e_out = 4'(i);
        cnt++;
      end
    end
    e_valid = (cnt > 0);
    e_multi = (cnt >= 2);
  endtask

  task automatic compare(input string tag);
    check({tag, ".out"}, 32'(out), 32'(e_out));
    check({tag, ".valid"}, 32'(valid), 32'(e_valid));
`ifdef ENCODER_16X4_MULTI_EN
    check({tag, ".multi"}, 32'(multi), 32'(e_multi));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"}, 32'(out), 32'd0);
    check({tag, ".valid"}, 32'(valid), 32'd0);
`ifdef ENCODER_16X4_MULTI_EN
    check({tag, ".multi"}, 32'(multi), 32'd0);
`endif
  endtask

  // Check the result of the previous vector, then apply the next one.
  task automatic step(input logic [15:0] v, input string tag);
    @(negedge clk);
    if (have_exp) compare(prev_tag);
    in = v;
    model(v);
    have_exp = 1'b1;
    prev_tag = tag;
  endtask

  logic [15:0] multi_tab [6] = '{16'h980C, 16'h8004, 16'hAAA0, 16'hFFFF, 16'h0C00, 16'h0006};

  initial begin
    rst = 1'b1;
    in  = 16'hFFFF;
    #2;
    check_zero("reset_async");
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    rst = 1'b0;
    model(in);
    have_exp = 1'b1;
    prev_tag = "reset_release";

    for (int i = 0; i < 16; i++) step(16'(1) << i, $sformatf("onehot%0d", i));
    for (int i = 0; i < 6; i++) step(multi_tab[i], $sformatf("multi_%04h", multi_tab[i]));
    step(16'h0000, "zero");
    step(16'h0001, "bit0");
    for (int i = 0; i < 10; i++) step((i % 2) ? 16'h4000 : 16'h0010, $sformatf("alt%0d", i));

    // Reset mid-stream: the pending result is discarded.
    step(16'h0123, "pre_reset");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midreset_async");
    have_exp = 1'b0;
    @(negedge clk);
    in = 16'h0C00;
    @(negedge clk);
    check_zero("midreset_held");
    rst = 1'b0;
    model(in);
    have_exp = 1'b1;
    prev_tag = "midreset_release";

    for (int n = 0; n < 400; n++) begin
      logic [15:0] v;
      case ($urandom_range(0, 3))
        0:       v = 16'(1) << $urandom_range(0, 15);
        1:       v = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom) & 16'($urandom);
        default: v = 16'($urandom);
      endcase
      step(v, $sformatf("rand%0d_%04h", n, v));
    end

    @(negedge clk);
    if (have_exp) compare(prev_tag);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
